// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: password-gated parking entry FSM with occupancy tracking,
// retry lockout, full-lot refusal and blinking gate indicators.
module parking_gate_ctrl #(
    parameter int CAPACITY = 8,
    parameter int PW_WIDTH = 2,
    parameter logic [PW_WIDTH-1:0] PASSWORD_1 = 2'b01,
    parameter logic [PW_WIDTH-1:0] PASSWORD_2 = 2'b10,
    parameter int WAIT_CYCLES = 4,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int BLINK_DIV = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            sensor_entrance,
    input  logic                            sensor_exit,
    input  logic                            car_leave,
    input  logic [PW_WIDTH-1:0]             password_1,
    input  logic [PW_WIDTH-1:0]             password_2,
    input  logic                            pw_valid,
    output logic                            GREEN_LED,
    output logic                            RED_LED,
    output logic [6:0]                      HEX_1,
    output logic [6:0]                      HEX_2,
    output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
    output logic                            full,
    output logic                            lockout
);
    localparam int OW = $clog2(CAPACITY + 1);
    localparam int WW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int LW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_OFF = 7'b1111111, SEG_E = 7'b0000110, SEG_N = 7'b0101011,
                           SEG_6 = 7'b0000010, SEG_0 = 7'b1000000, SEG_5 = 7'b0010010,
                           SEG_P = 7'b0001100, SEG_F = 7'b0001110, SEG_L = 7'b1000111;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WRONG, S_RIGHT, S_STOP, S_FULL, S_LOCKED
    } state_t;

    state_t state, state_next;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] tries;
    logic [LW-1:0] lock_cnt;
    logic [BW-1:0] blink_cnt;
    logic blink, tries_inc, green_d, red_d;
    logic [6:0] hex1_d, hex2_d;

    wire match     = pw_valid && password_1 == PASSWORD_1 && password_2 == PASSWORD_2;
    wire mismatch  = pw_valid && !match;
    wire wait_done = wait_cnt == WW'(WAIT_CYCLES - 1);
    wire tries_hit = tries == TW'(MAX_TRIES - 1);
    wire lock_done = lock_cnt == LW'(LOCK_CYCLES - 1);
    wire park_in   = state == S_RIGHT && sensor_exit && !sensor_entrance;

    assign full = occupancy == OW'(CAPACITY);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else state <= state_next;

    always_comb begin
        state_next = S_IDLE;
        tries_inc  = 1'b0;
        green_d    = 1'b0;
        red_d      = 1'b0;
        hex1_d     = SEG_OFF;
        hex2_d     = SEG_OFF;
        case (state)
            S_IDLE: state_next = sensor_entrance ? (full ? S_FULL : S_WAIT) : S_IDLE;
            S_WAIT: begin
                // A match in the timeout cycle still admits the driver
                tries_inc  = !match && (mismatch || wait_done);
                state_next = match ? S_RIGHT : tries_inc ? (tries_hit ? S_LOCKED : S_WRONG) : S_WAIT;
                red_d      = 1'b1;
                hex1_d     = SEG_E;
                hex2_d     = SEG_N;
            end
            S_WRONG: begin
                tries_inc  = mismatch;
                state_next = match ? S_RIGHT : (mismatch && tries_hit) ? S_LOCKED : S_WRONG;
                red_d      = blink;
                hex1_d     = SEG_E;
                hex2_d     = SEG_E;
            end
            S_RIGHT: begin
                state_next = sensor_exit ? (sensor_entrance ? S_STOP : S_IDLE) : S_RIGHT;
                green_d    = blink;
                hex1_d     = SEG_6;
                hex2_d     = SEG_0;
            end
            S_STOP: begin
                state_next = match ? S_RIGHT : S_STOP;
                red_d      = blink;
                hex1_d     = SEG_5;
                hex2_d     = SEG_P;
            end
            S_FULL: begin
                state_next = (sensor_entrance && full) ? S_FULL : S_IDLE;
                red_d      = 1'b1;
                hex1_d     = SEG_F;
                hex2_d     = SEG_L;
            end
            S_LOCKED: begin
                state_next = lock_done ? S_IDLE : S_LOCKED;
                red_d      = 1'b1;
                hex1_d     = SEG_L;
                hex2_d     = SEG_0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wait_cnt  <= '0;
            tries     <= '0;
            lock_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            occupancy <= '0;
        end else begin
            wait_cnt  <= state == S_WAIT ? wait_cnt + 1'b1 : '0;
            lock_cnt  <= (state == S_LOCKED && !lock_done) ? lock_cnt + 1'b1 : '0;
            blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
            blink     <= blink ^ (blink_cnt == BW'(BLINK_DIV - 1));
            if (state_next == S_RIGHT || (state == S_LOCKED && lock_done)) tries <= '0;
            else if (tries_inc) tries <= tries + 1'b1;
            // Simultaneous arrival and departure cancel out
            if (park_in && !car_leave && !full) occupancy <= occupancy + 1'b1;
            else if (car_leave && !park_in && occupancy != '0) occupancy <= occupancy - 1'b1;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            HEX_1     <= SEG_OFF;
            HEX_2     <= SEG_OFF;
            lockout   <= 1'b0;
        end else begin
            GREEN_LED <= green_d;
            RED_LED   <= red_d;
            HEX_1     <= hex1_d;
            HEX_2     <= hex2_d;
            lockout   <= state == S_LOCKED;
        end
endmodule
